vect_irq_arb: RTL and testbench

VECT_IRQ_ARB -- requirements
Module: vect_irq_arb

---
 rtl/vect_irq_pkg.sv | 21 ++
 rtl/prio_enc8.sv | 20 ++
 rtl/vect_irq_arb.sv | 99 +++++++++
 tb/tb_vect_irq_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vect_irq_pkg.sv
// Shared types and constants for the vectored interrupt arbiter.
//   state_t        : arbiter FSM states
//   NIRQ, IDW, AW  : source count, source-index width, vector address width
//   VBASE_DEFAULT  : default vector table base
//   VSHIFT_DEFAULT : default log2 spacing between vector entries
package vect_irq_pkg;

  localparam int unsigned NIRQ = 8;
  localparam int unsigned IDW  = 3;
  localparam int unsigned AW   = 12;

  localparam logic [AW-1:0] VBASE_DEFAULT  = 12'h0F0;
  localparam int unsigned   VSHIFT_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder; bit 0 has the highest priority.
//   req   : request vector
//   idx   : index of the lowest set bit (0 when none set)
//   valid : 1 when any request bit is set
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = 3'd0;
    valid = |req;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/vect_irq_arb.sv
// Vectored interrupt arbiter for a microprogram sequencer.
// Edge-detects eight request lines into a pending register, arbitrates the
// unmasked pending set by fixed priority, requests service from the
// sequencer and drives the winner's vector address onto the D bus.
//   CP, RESET_N         : clock, synchronous active-low reset
//   IRQ                 : level request lines
//   MASK_WE, MASK_D     : mask register write (1 = masked)
//   VECT_N, EOI         : vector-enable strobe, end-of-interrupt pulse
//   INT_N               : active-low request to the sequencer
//   DV, DV_OE           : vector address and its drive enable
//   ACTIVE, CUR_ID      : in-service flag and in-service source index
//   PEND                : pending register
module vect_irq_arb
  import vect_irq_pkg::*;
#(
  parameter logic [AW-1:0] VBASE  = VBASE_DEFAULT,
  parameter int unsigned   VSHIFT = VSHIFT_DEFAULT
) (
  input  logic            CP,
  input  logic            RESET_N,
  input  logic [NIRQ-1:0] IRQ,
  input  logic            MASK_WE,
  input  logic [NIRQ-1:0] MASK_D,
  input  logic            VECT_N,
  input  logic            EOI,
  output logic            INT_N,
  output logic [AW-1:0]   DV,
  output logic            DV_OE,
  output logic            ACTIVE,
  output logic [IDW-1:0]  CUR_ID,
  output logic [NIRQ-1:0] PEND
);

  state_t          state;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] pend_q;
  logic [NIRQ-1:0] mask_q;
  logic [IDW-1:0]  cur_id_q;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] clr;
  logic [NIRQ-1:0] pend_next;
  logic [IDW-1:0]  win;
  logic            any;
  logic            grant;
  logic [AW-1:0]   vec_addr;

  // Arbitration over the unmasked pending set.
  prio_enc8 u_prio (
    .req   (pend_q & ~mask_q),
    .idx   (win),
    .valid (any)
  );

  assign rise      = IRQ & ~irq_q;
  assign grant     = (state == REQ) && any && !VECT_N;
  assign clr       = grant ? (NIRQ'(1) << win) : '0;
  // Set after clear: a new edge on the granted bit keeps it pending.
  assign pend_next = (pend_q & ~clr) | rise;
  // Vector address wraps modulo the address width.
  assign vec_addr  = VBASE + (AW'(win) << VSHIFT);

  // State, pending, mask and in-service registers.
  always_ff @(posedge CP) begin
    if (!RESET_N) begin
      state    <= IDLE;
      irq_q    <= IRQ;
      pend_q   <= '0;
      mask_q   <= '1;
      cur_id_q <= '0;
    end else begin
      irq_q  <= IRQ;
      pend_q <= pend_next;
      if (MASK_WE) mask_q <= MASK_D;
      case (state)
        IDLE: if (any) state <= IDLE == IDLE ? REQ : IDLE;
        REQ: begin
          if (!any) begin
            state <= IDLE;
          end else if (!VECT_N) begin
            cur_id_q <= win;
            state    <= SVC;
          end
        end
        SVC:     if (EOI) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from the state register.
  assign INT_N  = (state != REQ);
  assign DV_OE  = (state == REQ) && !VECT_N;
  assign DV     = (state == REQ) ? vec_addr : '0;
  assign ACTIVE = (state == SVC);
  assign CUR_ID = cur_id_q;
  assign PEND   = pend_q;

endmodule

// File: tb/tb_vect_irq_arb.sv
module tb_vect_irq_arb;

  logic        CP = 1'b0;
  logic        RESET_N;
  logic [7:0]  IRQ;
  logic        MASK_WE;
  logic [7:0]  MASK_D;
  logic        VECT_N;
  logic        EOI;

  logic        INT_N, DV_OE, ACTIVE;
  logic [11:0] DV;
  logic [2:0]  CUR_ID;
  logic [7:0]  PEND;

  logic        INT_N2, DV_OE2, ACTIVE2;
  logic [11:0] DV2;
  logic [2:0]  CUR_ID2;
  logic [7:0]  PEND2;

  int total  = 0;
  int passed = 0;

  always #5 CP = ~CP;

  vect_irq_arb dut (
    .CP(CP), .RESET_N(RESET_N), .IRQ(IRQ), .MASK_WE(MASK_WE), .MASK_D(MASK_D),
    .VECT_N(VECT_N), .EOI(EOI), .INT_N(INT_N), .DV(DV), .DV_OE(DV_OE),
    .ACTIVE(ACTIVE), .CUR_ID(CUR_ID), .PEND(PEND)
  );

  vect_irq_arb #(.VBASE(12'hFF0), .VSHIFT(3)) dut_wrap (
    .CP(CP), .RESET_N(RESET_N), .IRQ(IRQ), .MASK_WE(MASK_WE), .MASK_D(MASK_D),
    .VECT_N(VECT_N), .EOI(EOI), .INT_N(INT_N2), .DV(DV2), .DV_OE(DV_OE2),
    .ACTIVE(ACTIVE2), .CUR_ID(CUR_ID2), .PEND(PEND2)
  );

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_mask(input logic [7:0] m);
    MASK_WE = 1'b1; MASK_D = m;
    tick();
    MASK_WE = 1'b0;
  endtask

  task automatic eoi_pulse();
    EOI = 1'b1;
    tick();
    EOI = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; IRQ = '0; MASK_WE = 1'b0; MASK_D = '0; VECT_N = 1'b1; EOI = 1'b0;
    #2;
    tick(); tick();
    // Reset state
    chk("rst_int_n", 32'(INT_N), 32'h1);
    chk("rst_dv", 32'(DV), 32'h0);
    chk("rst_dv_oe", 32'(DV_OE), 32'h0);
    chk("rst_active", 32'(ACTIVE), 32'h0);
    chk("rst_cur_id", 32'(CUR_ID), 32'h0);
    chk("rst_pend", 32'(PEND), 32'h0);
    RESET_N = 1'b1;
    tick();
    set_mask(8'h00);

    // Single source IRQ[2]
    IRQ = 8'h04;
    tick();
    chk("t1_pend", 32'(PEND), 32'h04);
    chk("t1_idle_int_n", 32'(INT_N), 32'h1);
    tick();
    chk("t1_int_n", 32'(INT_N), 32'h0);
    chk("t1_dv", 32'(DV), 32'h100);
    chk("t1_dv_oe_off", 32'(DV_OE), 32'h0);
    VECT_N = 1'b0; #1;
    chk("t1_dv_oe", 32'(DV_OE), 32'h1);
    chk("t1_dv_strobe", 32'(DV), 32'h100);
    tick();
    VECT_N = 1'b1; #1;
    chk("t1_active", 32'(ACTIVE), 32'h1);
    chk("t1_cur_id", 32'(CUR_ID), 32'h2);
    chk("t1_pend_clr", 32'(PEND), 32'h00);
    chk("t1_svc_int_n", 32'(INT_N), 32'h1);
    VECT_N = 1'b0; #1;
    chk("t1_svc_dv_oe", 32'(DV_OE), 32'h0);
    chk("t1_svc_dv", 32'(DV), 32'h0);
    tick();
    chk("t1_svc_vect_ignored", 32'(ACTIVE), 32'h1);
    VECT_N = 1'b1;
    eoi_pulse();
    chk("t1_eoi_active", 32'(ACTIVE), 32'h0);
    tick();
    chk("t1_level_no_edge", 32'(INT_N), 32'h1);
    IRQ = 8'h00;
    tick();

    // IRQ[5] and IRQ[1] together
    IRQ = 8'h22;
    tick();
    chk("t2_pend", 32'(PEND), 32'h22);
    tick();
    chk("t2_dv1", 32'(DV), 32'h0F8);
    VECT_N = 1'b0;
    tick();
    VECT_N = 1'b1;
    chk("t2_cur_id1", 32'(CUR_ID), 32'h1);
    chk("t2_pend1", 32'(PEND), 32'h20);
    eoi_pulse();
    tick();
    chk("t2_int_n2", 32'(INT_N), 32'h0);
    chk("t2_dv2", 32'(DV), 32'h118);
    VECT_N = 1'b0;
    tick();
    VECT_N = 1'b1;
    chk("t2_cur_id2", 32'(CUR_ID), 32'h5);
    chk("t2_pend2", 32'(PEND), 32'h00);
    eoi_pulse();
    IRQ = 8'h00;
    tick();

    // Masked pending, unmask, EOI in REQ ignored, mask drop in REQ
    set_mask(8'hFF);
    IRQ = 8'h01;
    tick();
    IRQ = 8'h00;
    chk("t3_pend_masked", 32'(PEND), 32'h01);
    tick(); tick();
    chk("t3_masked_int_n", 32'(INT_N), 32'h1);
    set_mask(8'hFE);
    tick();
    chk("t3_unmask_int_n", 32'(INT_N), 32'h0);
    eoi_pulse();
    chk("t3_eoi_in_req", 32'(INT_N), 32'h0);
    set_mask(8'hFF);
    chk("t3_mask_write_req", 32'(INT_N), 32'h0);
    tick();
    chk("t3_mask_drop_int_n", 32'(INT_N), 32'h1);
    chk("t3_mask_drop_pend", 32'(PEND), 32'h01);
    set_mask(8'h00);
    tick();
    VECT_N = 1'b0;
    tick();
    VECT_N = 1'b1;
    chk("t3_cur_id", 32'(CUR_ID), 32'h0);
    chk("t3_pend_clr", 32'(PEND), 32'h00);
    eoi_pulse();

    // Re-trigger of in-service source; set wins over grant clear
    IRQ = 8'h08;
    tick();
    IRQ = 8'h00;
    tick();
    VECT_N = 1'b0;
    tick();
    VECT_N = 1'b1;
    chk("t4_cur_id", 32'(CUR_ID), 32'h3);
    IRQ = 8'h08;
    tick();
    IRQ = 8'h00;
    chk("t4_pend_in_svc", 32'(PEND), 32'h08);
    tick();
    chk("t4_no_nest", 32'(INT_N), 32'h1);
    eoi_pulse();
    tick();
    chk("t4_rereq", 32'(INT_N), 32'h0);
    chk("t4_rereq_dv", 32'(DV), 32'h108);
    IRQ = 8'h08; VECT_N = 1'b0;
    tick();
    IRQ = 8'h00; VECT_N = 1'b1;
    chk("t4_set_wins", 32'(PEND), 32'h08);
    chk("t4_set_wins_active", 32'(ACTIVE), 32'h1);
    eoi_pulse();
    tick();
    VECT_N = 1'b0;
    tick();
    VECT_N = 1'b1;
    chk("t4_final_pend", 32'(PEND), 32'h00);
    eoi_pulse();

    // IRQ[7] with address wrap; mask write coincident with grant
    IRQ = 8'h80;
    tick();
    IRQ = 8'h00;
    tick();
    chk("t5_dv", 32'(DV), 32'h128);
    chk("t5_wrap_int_n", 32'(INT_N2), 32'h0);
    chk("t5_wrap_dv", 32'(DV2), 32'h028);
    VECT_N = 1'b0; MASK_WE = 1'b1; MASK_D = 8'hFF;
    #1;
    chk("t5_wrap_dv_oe", 32'(DV_OE2), 32'h1);
    tick();
    VECT_N = 1'b1; MASK_WE = 1'b0;
    chk("t5_grant_pre_mask", 32'(ACTIVE), 32'h1);
    chk("t5_cur_id", 32'(CUR_ID), 32'h7);
    chk("t5_wrap_active", 32'(ACTIVE2), 32'h1);
    chk("t5_wrap_cur_id", 32'(CUR_ID2), 32'h7);
    chk("t5_wrap_pend", 32'(PEND2), 32'h00);
    eoi_pulse();
    set_mask(8'h00);

    // Reset during service with a line held high
    IRQ = 8'h10;
    tick(); tick();
    VECT_N = 1'b0;
    tick();
    VECT_N = 1'b1;
    chk("t6_cur_id", 32'(CUR_ID), 32'h4);
    RESET_N = 1'b0;
    tick();
    chk("t6_rst_active", 32'(ACTIVE), 32'h0);
    chk("t6_rst_int_n", 32'(INT_N), 32'h1);
    chk("t6_rst_pend", 32'(PEND), 32'h00);
    chk("t6_rst_cur_id", 32'(CUR_ID), 32'h0);
    RESET_N = 1'b1;
    tick();
    set_mask(8'h00);
    tick(); tick();
    chk("t6_no_req_after", 32'(INT_N), 32'h1);
    chk("t6_no_pend_after", 32'(PEND), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
